uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter: the far end of the io block's UART transmit interface.
- Consumes the tx byte and transmit control bit driven by io (or by the bootloader when boot_en is set).
- Serialises the byte as an 8-N/E/O-1/2 frame on txd.
- Returns a done/idle status level that io samples into uart_control[1].

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate; DIV = CLK_HZ/BAUD (truncated) clocks per bit; DIV < 2 is an elaboration error.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- txd_data  in  8  byte to send; sampled only on the start cycle.
- transmit  in  1  request level; its rising edge starts a frame.
- txd_done  out  1  high when idle/frame complete (status level).
- busy  out  1  high while a frame is in progress (inverse of txd_done).
- txd  out  1  serial line, idle high, registered.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Outputs: txd=1, txd_done=1, busy=0.
  - Internal: state=IDLE, baud counter=0, bit index=0, transmit_q=0.
  - A frame in progress is aborted with no partial stop bit.
- Edge detect:
  - transmit_q <= transmit every cycle; start = transmit & ~transmit_q & (state==IDLE).
  - transmit held high out of reset counts as an edge and sends one frame.
  - Rising edges while state!=IDLE are dropped, not queued.
  - Holding transmit high never retriggers.
- Start cycle (cycle N):
  - Latch txd_data into the shift register.
  - Compute parity: even = XOR of the 8 bits; odd = its inverse.
  - Next state START; baud counter cleared.
- Cycle N+1: txd=0, txd_done=0, busy=1. Latency from edge sample to txd falling is 1 cycle.
- State machine: IDLE -> START -> DATA -> [PARITY, if PARITY!=0] -> STOP -> IDLE.
  - START: txd=0 for DIV cycles.
  - DATA: txd = shift[0], LSB first; shift right every DIV cycles; 8 bits, bit index 0..7.
  - PARITY: txd = parity bit for DIV cycles.
  - STOP: txd=1 for STOP_BITS*DIV cycles.
- Baud counter:
  - Width clog2(DIV); counts 0..DIV-1 and wraps to 0 on each bit boundary.
  - The state/bit advance happens on the cycle the counter equals DIV-1.
- End of frame:
  - On the last STOP cycle, state returns to IDLE; txd_done=1 and busy=0 from the next cycle.
  - txd_done stays low for exactly DIV*(1+8+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back frames:
  - The first cycle with registered state==IDLE accepts a new edge.
  - The minimum inter-frame gap is therefore 0 idle bit-times beyond the stop bit(s).
- txd_data changes after the start cycle have no effect on the frame in flight.
- All outputs are registered; there are no combinational paths from inputs to txd, txd_done or busy.

Test Plan:
- Reset: assert rst mid-idle and check txd=1, txd_done=1, busy=0 asynchronously. After release with transmit=0, txd stays 1 for 1000 cycles.
- Basic frame (CLK_HZ=1000000, BAUD=100000, DIV=10, PARITY=0):
  - Stimulus: txd_data=0x55, transmit 0->1.
  - Required: txd falls 1 cycle after the edge cycle, then 10-cycle bits 0,1,0,1,0,1,0,1,0 followed by stop 1.
  - txd_done is low for exactly 100 cycles.
- Edge handling (DIV=10, PARITY=0):
  - Pulse transmit again at cycle 30 of the frame, with txd_data changed to 0xFF: frame still carries 0x55, with no second frame.
  - Hold transmit high through the end of the frame: no retrigger.
  - Drop transmit, then raise it with 0xA3: bits 1,1,0,0,0,1,0,1 are sent.
- Parity:
  - PARITY=1, data 0x07: parity bit 1, frame 110 cycles.
  - PARITY=2, data 0x07: parity bit 0.
  - PARITY=1, data 0x00: parity bit 0.
- STOP_BITS=2, DIV=10: txd high for 20 cycles after the last data bit; txd_done low for 110 cycles.
- Reset mid-frame at frame cycle 35: txd=1 and txd_done=1 immediately. A subsequent 0->1 edge with 0x3C sends a complete, correct fresh frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Transmit-side handshake between the io block (or the bootloader) and the
// UART serialiser: the byte and start request going in, status and line out.
interface uart_tx_if;
  logic [7:0] txd_data;
  logic       transmit;
  logic       txd_done;
  logic       busy;
  logic       txd;

  // Requester side: drives the byte and the transmit level, watches status.
  modport master (
    output txd_data,
    output transmit,
    input  txd_done,
    input  busy,
    input  txd
  );

  // Serialiser side.
  modport slave (
    input  txd_data,
    input  transmit,
    output txd_done,
    output busy,
    output txd
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: a rising edge on transmit (while idle) latches txd_data
// and sends start, 8 data bits LSB first, optional parity and 1 or 2 stop
// bits on txd. txd, txd_done and busy are all registered, so nothing from
// the inputs reaches the outputs combinationally.
module uart_tx #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Reject parameter sets the bit timing or frame format cannot honour.
  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic             stop_idx_reg, stop_idx_next;
  logic             transmit_q;
  logic             txd_reg, txd_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             start;
  logic             bit_end;

  // A new frame is accepted only on a fresh rising edge seen while idle;
  // edges during a frame are simply lost.
  assign start   = tx.transmit & ~transmit_q & (state_reg == S_IDLE);
  assign bit_end = (cnt_reg == CNT_LAST);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    stop_idx_next = stop_idx_reg;
    txd_next      = 1'b1;
    done_next     = 1'b1;
    busy_next     = 1'b0;

    if (state_reg != S_IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        cnt_next      = '0;
        bit_idx_next  = '0;
        stop_idx_next = 1'b0;
        if (start) begin
          shift_next  = tx.txd_data;
          parity_next = (PARITY == 2) ? ~(^tx.txd_data) : (^tx.txd_data);
          state_next  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_reg == STOP_LAST) begin
            state_next = S_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so that they appear on
    // the flops exactly when that state becomes current.
    case (state_next)
      S_IDLE:   txd_next = 1'b1;
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shift_next[0];
      S_PARITY: txd_next = parity_next;
      S_STOP:   txd_next = 1'b1;
      default:  txd_next = 1'b1;
    endcase
    done_next = (state_next == S_IDLE);
    busy_next = (state_next != S_IDLE);
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      stop_idx_reg <= 1'b0;
      transmit_q   <= 1'b0;
      txd_reg      <= 1'b1;
      done_reg     <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      stop_idx_reg <= stop_idx_next;
      transmit_q   <= tx.transmit;
      txd_reg      <= txd_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  assign tx.txd      = txd_reg;
  assign tx.txd_done = done_reg;
  assign tx.busy     = busy_reg;

endmodule
